// File: rtl/mmio_fifo_ctrl.sv
// MMIO sequencer for a show-ahead FIFO: push/pop, status/ctrl CSRs, clear FSM.
// Optional MMIO_FIFO_CTRL_STATS_EN adds saturating overflow/underflow counters.
module mmio_fifo_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_wr_valid,
  input  logic        mmio_rd_valid,
  input  logic [15:0] mmio_addr,
  input  logic [8:0]  mmio_tid,
  input  logic [63:0] mmio_wr_data,
  output logic        rsp_valid,
  output logic [8:0]  rsp_tid,
  output logic [63:0] rsp_data,
  output logic        fifo_push,
  output logic [63:0] fifo_wdata,
  output logic        fifo_pop,
  input  logic [63:0] fifo_rdata
);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [15:0] A_DATA  = 16'h0020;
  localparam logic [15:0] A_STAT  = 16'h0022;
  localparam logic [15:0] A_CTRL  = 16'h0024;
  localparam logic [15:0] A_STATS = 16'h0026;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            rsp_valid_q;
  logic [8:0]      rsp_tid_q;
  logic [63:0]     rsp_data_q, rsp_data_d;
  logic            full, empty;
  logic            wr_dat, rd_dat, wr_ctl;
  logic            push, pop;
  logic            ovf_inc, udf_inc;
  logic [63:0]     dat_word, stat_word;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_dat = mmio_wr_valid && (mmio_addr == A_DATA);
  assign rd_dat = mmio_rd_valid && (mmio_addr == A_DATA);
  assign wr_ctl = mmio_wr_valid && (mmio_addr == A_CTRL);

  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    pop      = 1'b0;
    ovf_inc  = 1'b0;
    udf_inc  = 1'b0;
    dat_word = '0;
    unique case (state_q)
      IDLE: begin
        // a full FIFO still accepts a write when a read frees the head
        pop      = rd_dat && !empty;
        push     = wr_dat && (!full || pop);
        dat_word = pop ? fifo_rdata : '0;
        ovf_inc  = wr_dat && !push;
        udf_inc  = rd_dat && !pop;
        if (wr_ctl && mmio_wr_data[0]) state_d = CLEAR;
      end
      CLEAR: begin
        pop     = !empty;
        ovf_inc = wr_dat;
        udf_inc = rd_dat;
        if (empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      push = 1'b0;
      pop  = 1'b0;
    end
  end

  assign count_d    = count_q + CW'(push) - CW'(pop);
  assign fifo_push  = push;
  assign fifo_pop   = pop;
  assign fifo_wdata = mmio_wr_data;

  assign stat_word = {44'b0, state_q, 8'b0, 8'(count_q), full, empty};

`ifdef MMIO_FIFO_CTRL_STATS_EN
  logic [31:0] ovf_q, udf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
      udf_q <= '0;
    end else if (mmio_wr_valid && (mmio_addr == A_STATS)) begin
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      if (ovf_inc && (ovf_q != '1)) ovf_q <= ovf_q + 32'd1;
      if (udf_inc && (udf_q != '1)) udf_q <= udf_q + 32'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = ^{ovf_inc, udf_inc};
`endif

  always_comb begin
    rsp_data_d = '0;
    if (mmio_addr == A_DATA)      rsp_data_d = dat_word;
    else if (mmio_addr == A_STAT) rsp_data_d = stat_word;
`ifdef MMIO_FIFO_CTRL_STATS_EN
    else if (mmio_addr == A_STATS) rsp_data_d = {udf_q, ovf_q};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rsp_valid_q <= mmio_rd_valid;
      if (mmio_rd_valid) begin
        rsp_tid_q  <= mmio_tid;
        rsp_data_q <= rsp_data_d;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_tid   = rsp_tid_q;
  assign rsp_data  = rsp_data_q;
endmodule
